// File: rtl/mux_pkg.sv
// Shared constants and mode encodings for the round-robin stream multiplexer.
package mux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_NCH   = 4;
    localparam int unsigned CNT_W         = 16;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester strictly after ptr, wrapping modulo NCH.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned NCH  = DEFAULT_NCH,
    parameter int unsigned SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest valid candidate is the last write.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int off = int'(NCH); off >= 1; off--) begin
            cand = SELW'((32'(ptr) + 32'(off)) % NCH);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with directed or round-robin selection into a single
// registered output slot; counts every word loaded.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NCH   = DEFAULT_NCH,
    parameter int unsigned SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      cntrl,
    input  logic [NCH*WIDTH-1:0] arg,
    input  logic [NCH-1:0]       arg_valid,
    output logic [NCH-1:0]       arg_ready,
    output logic [WIDTH-1:0]     dout,
    output logic [SELW-1:0]      dout_chan,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [CNT_W-1:0]     xfer_cnt
);

    localparam logic [SELW-1:0] PTR_RST = SELW'(NCH - 1);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SELW-1:0]  chan_q, chan_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             rr_vld;
    logic [SELW-1:0]  rr_idx;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             load_en;
    logic             load;

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req     (arg_valid),
        .ptr     (rr_ptr_q),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    assign load_en = !valid_q || dout_ready;
    assign load    = load_en && gnt_vld;

    // Directed mode matches cntrl against real channels only, so unused codes never grant.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (mode == MODE_RR) begin
            gnt_vld = rr_vld;
            gnt_idx = rr_idx;
        end else begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (cntrl == SELW'(i) && arg_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cntrl;
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (gnt_idx == SELW'(i)) begin
                gnt_data = arg[i*WIDTH +: WIDTH];
            end
        end
    end

    // rst_n gating keeps every channel stalled while the block is held in reset.
    always_comb begin
        arg_ready = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            arg_ready[i] = rst_n && load && (gnt_idx == SELW'(i));
        end
    end

    always_comb begin
        dout_d   = dout_q;
        chan_d   = chan_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        if (load_en) begin
            valid_d = gnt_vld;
        end
        if (load) begin
            dout_d = gnt_data;
            chan_d = gnt_idx;
            cnt_d  = cnt_q + CNT_W'(1);
            if (mode == MODE_RR) begin
                rr_ptr_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q   <= '0;
            chan_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            rr_ptr_q <= PTR_RST;
        end else begin
            dout_q   <= dout_d;
            chan_q   <= chan_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_chan  = chan_q;
    assign dout_valid = valid_q;
    assign xfer_cnt   = cnt_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(arg_ready));
    a_stall_no_ready: assert property (@(posedge clk) disable iff (!rst_n)
        (valid_q && !dout_ready) |-> (arg_ready == '0));

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized and directed bench for stream_mux_rr against a cycle-level reference model.
module tb_stream_mux_rr;

    localparam int W = 16;
    localparam int N = 4;
    localparam int S = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           mode;
    logic [S-1:0]   cntrl;
    logic [N*W-1:0] arg;
    logic [N-1:0]   arg_valid;
    logic [N-1:0]   arg_ready;
    logic [W-1:0]   dout;
    logic [S-1:0]   dout_chan;
    logic           dout_valid;
    logic           dout_ready;
    logic [15:0]    xfer_cnt;

    logic           m3;
    logic [1:0]     c3;
    logic [23:0]    a3;
    logic [2:0]     v3;
    logic [2:0]     rdy3;
    logic [7:0]     d3;
    logic [1:0]     ch3;
    logic           dv3;
    logic           r3;
    logic [15:0]    cnt3;

    stream_mux_rr #(
        .WIDTH (W),
        .NCH   (N),
        .SELW  (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .cntrl      (cntrl),
        .arg        (arg),
        .arg_valid  (arg_valid),
        .arg_ready  (arg_ready),
        .dout       (dout),
        .dout_chan  (dout_chan),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .xfer_cnt   (xfer_cnt)
    );

    stream_mux_rr #(
        .WIDTH (8),
        .NCH   (3),
        .SELW  (2)
    ) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (m3),
        .cntrl      (c3),
        .arg        (a3),
        .arg_valid  (v3),
        .arg_ready  (rdy3),
        .dout       (d3),
        .dout_chan  (ch3),
        .dout_valid (dv3),
        .dout_ready (r3),
        .xfer_cnt   (cnt3)
    );

    // Reference model state: contents of the output slot, rotation pointer, load count.
    logic [W-1:0] m_dout;
    int           m_chan;
    logic         m_valid;
    int           m_ptr;
    logic [15:0]  m_cnt;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_dout  = '0;
        m_chan  = 0;
        m_valid = 1'b0;
        m_ptr   = N - 1;
        m_cnt   = '0;
    endfunction

    function automatic void model_grant(output logic gv, output int g);
        int c;
        gv = 1'b0;
        g  = 0;
        if (mode == 1'b0) begin
            if (int'(cntrl) < N && arg_valid[cntrl]) begin
                gv = 1'b1;
                g  = int'(cntrl);
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (arg_valid[c]) begin
                    gv = 1'b1;
                    g  = c;
                    break;
                end
            end
        end
    endfunction

    // Called at posedge+1 with inputs already applied; compares at negedge, then advances.
    task automatic step();
        logic       gv;
        int         g;
        logic       le;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        model_grant(gv, g);
        le      = !m_valid || dout_ready;
        exp_rdy = (le && gv) ? N'(1 << g) : '0;
        check("arg_ready", 64'(arg_ready), 64'(exp_rdy));
        check("dout_valid", 64'(dout_valid), 64'(m_valid));
        check("dout", 64'(dout), 64'(m_dout));
        check("dout_chan", 64'(dout_chan), 64'(m_chan));
        check("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
        if (le) begin
            if (gv) begin
                m_dout  = arg[g*W +: W];
                m_chan  = g;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 16'd1;
                if (mode) m_ptr = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        arg_valid = '1;
        mode      = 1'b0;
        cntrl     = '0;
        #2 rst_n  = 1'b0;
        #1;
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_chan", 64'(dout_chan), 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_cnt", 64'(xfer_cnt), 64'd0);
        check("rst_ready", 64'(arg_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int exp_seq [5] = '{0, 1, 2, 3, 0};
    int exp_alt [4] = '{1, 3, 1, 3};
    int exp_rr3 [4] = '{0, 1, 2, 0};

    initial begin
        rst_n      = 1'b1;
        mode       = 1'b0;
        cntrl      = '0;
        arg        = '0;
        arg_valid  = '0;
        dout_ready = 1'b1;
        m3 = 1'b0; c3 = '0; a3 = '0; v3 = '0; r3 = 1'b1;
        model_reset();

        // Directed select of channel 2.
        apply_reset();
        arg        = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        arg_valid  = 4'b1111;
        mode       = 1'b0;
        cntrl      = 2'd2;
        dout_ready = 1'b1;
        step();
        check("sel_dout", 64'(dout), 64'hCCCC);
        check("sel_chan", 64'(dout_chan), 64'd2);
        check("sel_valid", 64'(dout_valid), 64'd1);

        // Round-robin from reset, all channels valid.
        apply_reset();
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_seq", 64'(dout_chan), 64'(exp_seq[i]));
        end
        check("rr_cnt5", 64'(xfer_cnt), 64'd5);

        // Only channels 1 and 3 request.
        arg_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_alt", 64'(dout_chan), 64'(exp_alt[i]));
        end

        // Backpressure with AAAA held, then drain and load on one edge.
        mode = 1'b0; cntrl = 2'd0; arg_valid = 4'b1111;
        step();
        check("bp_load", 64'(dout), 64'hAAAA);
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold", 64'(dout), 64'hAAAA);
        end
        dout_ready = 1'b1;
        cntrl      = 2'd1;
        step();
        check("bp_next", 64'(dout), 64'hBBBB);
        check("bp_valid", 64'(dout_valid), 64'd1);

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            mode       = 1'($urandom_range(0, 1));
            cntrl      = 2'($urandom_range(0, 3));
            arg_valid  = 4'($urandom_range(0, 15));
            arg        = {$urandom(), $urandom()};
            dout_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Counter wrap, then asynchronous reset mid-stream.
        apply_reset();
        mode = 1'b1; arg_valid = 4'b1111; dout_ready = 1'b1;
        arg  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int i = 0; i < 65535; i++) step();
        check("cnt_ffff", 64'(xfer_cnt), 64'hFFFF);
        step();
        check("cnt_wrap", 64'(xfer_cnt), 64'd0);
        step();
        step();
        apply_reset();
        mode = 1'b1; arg_valid = 4'b0110;
        for (int i = 0; i < 4; i++) step();

        // Three-channel instance: out-of-range select and pointer wrap.
        m3 = 1'b0; c3 = 2'd1; v3 = 3'b111; a3 = 24'h332211; r3 = 1'b1;
        @(negedge clk);
        check("n3_rdy_sel", 64'(rdy3), 64'b010);
        @(posedge clk); #1;
        check("n3_dout", 64'(d3), 64'h22);
        check("n3_chan", 64'(ch3), 64'd1);
        check("n3_valid", 64'(dv3), 64'd1);
        c3 = 2'd3;
        @(negedge clk);
        check("n3_rdy_oob", 64'(rdy3), 64'd0);
        @(posedge clk); #1;
        check("n3_drain", 64'(dv3), 64'd0);
        check("n3_hold", 64'(d3), 64'h22);
        check("n3_hold_chan", 64'(ch3), 64'd1);
        m3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("n3_rr", 64'(ch3), 64'(exp_rr3[i]));
        end
        check("n3_cnt", 64'(cnt3), 64'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width per channel.
REQ-002 The block SHALL have parameter NCH, default 4, giving the channel count, legal range 2..16.
REQ-003 The block SHALL have parameter SELW, default $clog2(NCH), giving the select/index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = directed select, 1 = round-robin.
REQ-007 The block SHALL have port cntrl, input, SELW bits: the channel index used in directed mode.
REQ-008 The block SHALL have port arg, input, NCH*WIDTH bits: channel data, with channel i at [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port arg_valid, input, NCH bits: per-channel data valid.
REQ-010 The block SHALL have port arg_ready, output, NCH bits: per-channel accept, one-hot or zero.
REQ-011 The block SHALL have port dout, output, WIDTH bits: the registered selected data.
REQ-012 The block SHALL have port dout_chan, output, SELW bits: the channel index of the dout contents.
REQ-013 The block SHALL have port dout_valid, output, 1 bit: dout holds an unconsumed word.
REQ-014 The block SHALL have port dout_ready, input, 1 bit: the downstream accept signal.
REQ-015 The block SHALL have port xfer_cnt, output, 16 bits: a count of words loaded into dout.

Function
REQ-016 The block SHALL compute load_en = !dout_valid | dout_ready, combinationally.
REQ-017 In directed mode, the block SHALL grant channel cntrl iff cntrl < NCH and arg_valid[cntrl]; otherwise it SHALL make no grant.
REQ-018 In round-robin mode, the block SHALL grant the first valid channel searching upward from rr_ptr+1 modulo NCH; if no channel is valid, it SHALL make no grant.
REQ-019 arg_ready[g] SHALL equal load_en & granted(g), and all other arg_ready bits SHALL be 0; arg_ready SHALL be combinational from the current inputs and state.
REQ-020 When a grant coincides with load_en, the block SHALL on the next edge set dout to arg[g], dout_chan to g, and dout_valid to 1 (latency 1 cycle).
REQ-021 When load_en is 1 and there is no grant, the block SHALL clear dout_valid on the next edge, and dout and dout_chan SHALL hold their values.
REQ-022 While dout_valid & !dout_ready, the block SHALL hold dout, dout_chan and dout_valid stable, with arg_ready all 0.
REQ-023 When drain and load occur in the same cycle, the block SHALL sustain full throughput of one word per cycle with no bubble.
REQ-024 rr_ptr SHALL update to g only on a load in round-robin mode; it SHALL be unchanged by directed-mode loads.
REQ-025 A mode or cntrl change SHALL affect only the next grant decision, never a word already held in dout.
REQ-026 xfer_cnt SHALL increment by 1 on every load and SHALL wrap from 16'hFFFF to 0.
REQ-027 With NCH not a power of 2, out-of-range cntrl values SHALL yield no grant, and rr_ptr SHALL never exceed NCH-1.

Reset
REQ-028 While rst_n = 0, the block SHALL set dout = 0, dout_chan = 0, dout_valid = 0, xfer_cnt = 0 and rr_ptr = NCH-1, so that channel 0 wins the first round-robin grant.
REQ-029 Reset assertion mid-transfer SHALL discard the held word immediately, and arg_ready SHALL be 0 while in reset.
REQ-030 After rst_n deasserts, the first load SHALL be possible on the first rising edge.

Structure
REQ-031 Shared package mux_pkg SHALL hold the default WIDTH/NCH constants and the mode encodings MODE_SEL = 1'b0 and MODE_RR = 1'b1.
REQ-032 The round-robin search SHALL be a combinational sub-module rr_arbiter (inputs: req, ptr; outputs: gnt_vld, gnt_idx), and the output register, counter and pointer SHALL reside in stream_mux_rr.

Verification
REQ-033 Directed mode, NCH=4, arg = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, all valid, cntrl=2, dout_ready=1 -> the cycle after, dout = CCCC, dout_chan = 2, dout_valid = 1, arg_ready = 4'b0100.
REQ-034 Round-robin mode, all valid, dout_ready=1 from reset -> dout_chan sequence 0,1,2,3,0; xfer_cnt = 5 after 5 cycles.
REQ-035 Round-robin mode, arg_valid = 4'b1010 -> dout_chan alternates 1,3,1,3, and arg_ready never selects channel 0 or 2.
REQ-036 Backpressure: dout_ready=0 for 3 cycles with dout = AAAA held -> dout stable, arg_ready = 0; dout_ready=1 -> the next word loads on the same edge as the drain.
REQ-037 Directed mode, NCH=3, cntrl=3 -> no grant, and dout_valid clears after the drain.
REQ-038 Preload xfer_cnt to 16'hFFFF by streaming, then load one more word -> xfer_cnt = 0; then pulse rst_n low mid-stream -> all outputs 0 asynchronously.
